// File: rtl/fifo_burst_arb_if.sv
// fifo_burst_arb_if: FIFO status, write-request and handshake bundle between the arbiter and its neighbours
interface fifo_burst_arb_if #(
  parameter int CH = 4,
  parameter int CW = 9,
  parameter int LSIZE = 9
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  logic [CH*CW-1:0] count;
  logic [CH-1:0] tail;
  logic [CH-1:0] fifo_empty;
  logic burst_req;
  logic tail_req;
  logic [CHW-1:0] req_ch;
  logic [LSIZE-1:0] req_len;
  logic resp;
  logic done;
  logic busy;
  modport master (
    input count, tail, fifo_empty, resp, done,
    output burst_req, tail_req, req_ch, req_len, busy
  );
  modport slave (
    output count, tail, fifo_empty, resp, done,
    input burst_req, tail_req, req_ch, req_len, busy
  );
endinterface

// File: rtl/fifo_burst_arb.sv
// fifo_burst_arb: round-robin burst/tail write-request arbiter over CH FIFOs; idle-flush timeout enabled by FIFO_BURST_ARB_TIMEOUT_EN
module fifo_burst_arb #(
  parameter int CH = 4,
  parameter int CW = 9,
  parameter int LSIZE = 9,
  parameter int THRESHOLD = 200,
  parameter int TIMEOUT = 1024
) (
  input logic clock,
  input logic rst_n,
  fifo_burst_arb_if.master bus
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CW-1:0] THR_C = CW'(THRESHOLD);
  localparam logic [LSIZE-1:0] THR_L = LSIZE'(THRESHOLD);
  typedef enum logic [2:0] {IDLE, REQ_BURST, REQ_TAIL, WAIT_DONE, FSH} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt [CH];
  logic [CH-1:0] burst_el_q, burst_el_d, tail_pend_q, tail_pend_d, cand, to_hit;
  logic [2*CH-1:0] cand_rot;
  logic [CHW-1:0] rr_q, rr_d, gnt, req_ch_q, req_ch_d;
  logic [LSIZE-1:0] req_len_q, req_len_d, gnt_len;
  logic found, grant, is_tail_q, burst_req_q, tail_req_q, busy_q;
  assign cand = (burst_el_q | tail_pend_q) & ~bus.fifo_empty;
  assign grant = state_q == IDLE && found;
  assign gnt_len = (burst_el_q[gnt] || cnt[gnt] > THR_C) ? THR_L : LSIZE'(cnt[gnt]);
  assign rr_d = grant ? ((gnt == CHW'(CH - 1)) ? '0 : gnt + 1'b1) : rr_q;
  assign req_ch_d = grant ? gnt : ((state_d == IDLE) ? '0 : req_ch_q);
  assign req_len_d = grant ? gnt_len : ((state_d == REQ_BURST || state_d == REQ_TAIL) ? req_len_q : '0);
  assign bus.burst_req = burst_req_q;
  assign bus.tail_req = tail_req_q;
  assign bus.req_ch = req_ch_q;
  assign bus.req_len = req_len_q;
  assign bus.busy = busy_q;
  // Unpack per-channel fill levels and derive next-cycle burst eligibility
  always_comb begin
    burst_el_d = '0;
    for (int i = 0; i < CH; i++) begin
      cnt[i] = bus.count[i*CW +: CW];
      burst_el_d[i] = cnt[i] > THR_C;
    end
  end
  // Rotate candidates so bit 0 is the rr pointer; the lowest set bit wins
  always_comb begin
    cand_rot = {cand, cand} >> rr_q;
    found = 1'b0;
    gnt = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      if (cand_rot[k]) begin
        found = 1'b1;
        gnt = CHW'((int'(rr_q) + k) % CH);
      end
    end
  end
`ifdef FIFO_BURST_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q [CH];
  logic [CH-1:0] idle_run;
  // A partially filled, unflagged, ungranted channel accumulates idle time; expiry flags a tail
  always_comb begin
    idle_run = '0;
    to_hit = '0;
    for (int i = 0; i < CH; i++) begin
      idle_run[i] = cnt[i] != '0 && cnt[i] <= THR_C && !tail_pend_q[i]
                    && !(state_q != IDLE && req_ch_q == CHW'(i)) && !(grant && gnt == CHW'(i));
      to_hit[i] = idle_run[i] && idle_q[i] == TW'(TIMEOUT - 1);
    end
  end
  // Idle counters per channel
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < CH; i++) idle_q[i] <= '0;
    else for (int i = 0; i < CH; i++) idle_q[i] <= idle_run[i] ? idle_q[i] + 1'b1 : '0;
  end
`else
  assign to_hit = '0;
`endif
  // Sticky tail flag: drained FIFO or completed tail service clears, and clear beats set
  always_comb begin
    tail_pend_d = tail_pend_q;
    for (int i = 0; i < CH; i++)
      tail_pend_d[i] = (cnt[i] == '0 || (state_q == WAIT_DONE && bus.done && is_tail_q && req_ch_q == CHW'(i))) ? 1'b0
                     : (bus.tail[i] || to_hit[i]) ? 1'b1 : tail_pend_q[i];
  end
  // Request FSM next state; a grant prefers burst over tail within the chosen channel
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (found) state_d = burst_el_q[gnt] ? REQ_BURST : REQ_TAIL;
      REQ_BURST, REQ_TAIL: if (bus.resp) state_d = WAIT_DONE;
      WAIT_DONE: if (bus.done) state_d = FSH;
      default: state_d = IDLE;
    endcase
  end
  // State, eligibility and outputs registered off the next state
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= '0;
      burst_el_q <= '0;
      tail_pend_q <= '0;
      req_ch_q <= '0;
      req_len_q <= '0;
      is_tail_q <= 1'b0;
      burst_req_q <= 1'b0;
      tail_req_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      burst_el_q <= burst_el_d;
      tail_pend_q <= tail_pend_d;
      req_ch_q <= req_ch_d;
      req_len_q <= req_len_d;
      is_tail_q <= grant ? state_d == REQ_TAIL : is_tail_q;
      burst_req_q <= state_d == REQ_BURST;
      tail_req_q <= state_d == REQ_TAIL;
      busy_q <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_fifo_burst_arb.sv
// tb_fifo_burst_arb: directed and randomized checks of fifo_burst_arb against a transaction-level arbitration model
module tb_fifo_burst_arb;
  localparam int CH = 4, CW = 9, LSIZE = 9, THR = 200, TMO = 16;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int total = 0, bad = 0;
  int m_rr = 0;
  int m_cnt [CH];
  bit m_burst [CH], m_tail [CH], m_empty [CH];
  always #5 clock = ~clock;
  fifo_burst_arb_if #(.CH(CH), .CW(CW), .LSIZE(LSIZE)) bus ();
  fifo_burst_arb #(.CH(CH), .CW(CW), .LSIZE(LSIZE), .THRESHOLD(THR), .TIMEOUT(TMO)) dut (
    .clock(clock), .rst_n(rst_n), .bus(bus)
  );
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic set_cnt(input int ch, input int v);
    bus.count[ch*CW +: CW] = CW'(v);
    bus.fifo_empty[ch] = (v == 0);
  endtask
  task automatic quiet();
    bus.count = '0;
    bus.tail = '0;
    bus.fifo_empty = '1;
    bus.resp = 1'b0;
    bus.done = 1'b0;
    repeat (3) tick();
  endtask
  task automatic wait_req(input int max, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max && !ok; k++) begin
      if (bus.burst_req || bus.tail_req) ok = 1'b1;
      else tick();
    end
  endtask
  task automatic finish_req();
    bus.resp = 1'b1;
    tick();
    bus.resp = 1'b0;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.count = '0;
    bus.tail = '0;
    bus.fifo_empty = '1;
    bus.resp = 1'b0;
    bus.done = 1'b0;
    repeat (2) tick();
    total++; if ({bus.burst_req, bus.tail_req, bus.busy} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {bus.burst_req, bus.tail_req, bus.busy}); end
    total++; if (bus.req_ch !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d want=0", bus.req_ch); end
    total++; if (bus.req_len !== 9'd0) begin bad++; $display("FAIL reset_len got=%0d want=0", bus.req_len); end
    rst_n = 1'b1;
    quiet();
    m_rr = 0;
  endtask
  task automatic test_burst();
    set_cnt(0, 201);
    tick();
    total++; if (bus.burst_req !== 1'b0) begin bad++; $display("FAIL burst_early got=%b want=0", bus.burst_req); end
    tick();
    total++; if ({bus.burst_req, bus.tail_req, bus.busy} !== 3'b101) begin bad++; $display("FAIL burst_flags got=%b want=101", {bus.burst_req, bus.tail_req, bus.busy}); end
    total++; if (bus.req_ch !== 2'd0 || bus.req_len !== 9'd200) begin bad++; $display("FAIL burst_chlen got=%0d/%0d want=0/200", bus.req_ch, bus.req_len); end
    bus.resp = 1'b1;
    tick();
    bus.resp = 1'b0;
    total++; if (bus.burst_req !== 1'b0 || bus.req_len !== 9'd0 || bus.busy !== 1'b1) begin bad++; $display("FAIL burst_resp got=%b/%0d/%b want=0/0/1", bus.burst_req, bus.req_len, bus.busy); end
    set_cnt(0, 0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL burst_fsh_busy got=%b want=1", bus.busy); end
    tick();
    total++; if (bus.busy !== 1'b0 || bus.req_ch !== 2'd0) begin bad++; $display("FAIL burst_idle got=%b/%0d want=0/0", bus.busy, bus.req_ch); end
    quiet();
    m_rr = 1;
  endtask
  task automatic test_round_robin();
    int exp_ch [4] = '{1, 3, 1, 3};
    bit ok;
    set_cnt(1, 250);
    set_cnt(3, 250);
    for (int k = 0; k < 4; k++) begin
      wait_req(10, ok);
      total++; if (!ok) begin bad++; $display("FAIL rr_timeout got=none want=grant%0d", k); end
      total++; if (bus.req_ch !== 2'(exp_ch[k]) || bus.burst_req !== 1'b1) begin bad++; $display("FAIL rr_grant%0d got=%0d/%b want=%0d/1", k, bus.req_ch, bus.burst_req, exp_ch[k]); end
      finish_req();
    end
    quiet();
    m_rr = 0;
  endtask
  task automatic test_tail();
    bit ok, seen;
    set_cnt(2, 37);
    bus.tail[2] = 1'b1;
    tick();
    bus.tail[2] = 1'b0;
    wait_req(10, ok);
    total++; if (!ok || bus.tail_req !== 1'b1 || bus.burst_req !== 1'b0) begin bad++; $display("FAIL tail_flags got=%b/%b want=1/0", bus.tail_req, bus.burst_req); end
    total++; if (bus.req_ch !== 2'd2 || bus.req_len !== 9'd37) begin bad++; $display("FAIL tail_chlen got=%0d/%0d want=2/37", bus.req_ch, bus.req_len); end
    finish_req();
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (bus.burst_req || bus.tail_req) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL tail_repeat got=%b want=0", seen); end
    quiet();
    m_rr = 3;
  endtask
  task automatic test_burst_then_tail();
    bit ok;
    set_cnt(1, 300);
    bus.tail[1] = 1'b1;
    tick();
    bus.tail[1] = 1'b0;
    wait_req(10, ok);
    total++; if (!ok || bus.burst_req !== 1'b1 || bus.req_ch !== 2'd1 || bus.req_len !== 9'd200) begin bad++; $display("FAIL bt_burst got=%b/%0d/%0d want=1/1/200", bus.burst_req, bus.req_ch, bus.req_len); end
    bus.resp = 1'b1;
    tick();
    bus.resp = 1'b0;
    set_cnt(1, 150);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    wait_req(10, ok);
    total++; if (!ok || bus.tail_req !== 1'b1 || bus.req_ch !== 2'd1 || bus.req_len !== 9'd150) begin bad++; $display("FAIL bt_tail got=%b/%0d/%0d want=1/1/150", bus.tail_req, bus.req_ch, bus.req_len); end
    finish_req();
    quiet();
    m_rr = 2;
  endtask
  task automatic test_resp_done_same();
    bit ok;
    set_cnt(0, 250);
    wait_req(10, ok);
    total++; if (!ok || bus.req_ch !== 2'd0) begin bad++; $display("FAIL rd_grant got=%b/%0d want=1/0", ok, bus.req_ch); end
    bus.resp = 1'b1;
    bus.done = 1'b1;
    tick();
    bus.resp = 1'b0;
    bus.done = 1'b0;
    repeat (2) tick();
    total++; if (bus.busy !== 1'b1 || bus.burst_req !== 1'b0) begin bad++; $display("FAIL rd_lost_done got=%b/%b want=1/0", bus.busy, bus.burst_req); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    set_cnt(0, 0);
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rd_idle got=%b want=0", bus.busy); end
    quiet();
    m_rr = 1;
  endtask
  task automatic test_async_reset();
    bit ok;
    set_cnt(2, 250);
    set_cnt(3, 250);
    wait_req(10, ok);
    total++; if (!ok || bus.req_ch !== 2'd2) begin bad++; $display("FAIL ar_first got=%0d want=2", bus.req_ch); end
    bus.resp = 1'b1;
    tick();
    bus.resp = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bus.burst_req, bus.tail_req, bus.busy} !== 3'b000 || bus.req_ch !== 2'd0 || bus.req_len !== 9'd0) begin bad++; $display("FAIL ar_clear got=%b/%0d/%0d want=000/0/0", {bus.burst_req, bus.tail_req, bus.busy}, bus.req_ch, bus.req_len); end
    tick();
    rst_n = 1'b1;
    wait_req(10, ok);
    total++; if (!ok || bus.req_ch !== 2'd2) begin bad++; $display("FAIL ar_regrant got=%0d want=2", bus.req_ch); end
    finish_req();
    quiet();
    m_rr = 3;
  endtask
  task automatic test_timeout();
    bit ok, seen;
    set_cnt(0, 5);
`ifdef FIFO_BURST_ARB_TIMEOUT_EN
    wait_req(30, ok);
    total++; if (!ok || bus.tail_req !== 1'b1 || bus.req_ch !== 2'd0 || bus.req_len !== 9'd5) begin bad++; $display("FAIL to_flush got=%b/%0d/%0d want=1/0/5", bus.tail_req, bus.req_ch, bus.req_len); end
    finish_req();
    ok = 1'b0;
    seen = ok;
`else
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (bus.burst_req || bus.tail_req) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL to_none got=%b want=0", seen); end
`endif
    quiet();
  endtask
  task automatic test_random();
    bit ok, seen, exp_tail;
    int kind, e, c, exp_len;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_rr = 0;
    for (int s = 0; s < 10; s++) begin
      for (int i = 0; i < CH; i++) begin
`ifdef FIFO_BURST_ARB_TIMEOUT_EN
        kind = 2 * $urandom_range(0, 1);
`else
        kind = $urandom_range(0, 3);
`endif
        m_cnt[i] = (kind == 0) ? 0 : (kind == 2) ? $urandom_range(201, 511) : $urandom_range(1, 200);
        m_burst[i] = m_cnt[i] > THR;
        m_empty[i] = (m_cnt[i] == 0) || ($urandom_range(0, 3) == 0);
        m_tail[i] = m_cnt[i] != 0 && kind != 3 && $urandom_range(0, 1) == 1;
        bus.count[i*CW +: CW] = CW'(m_cnt[i]);
        bus.fifo_empty[i] = m_empty[i];
        bus.tail[i] = m_tail[i];
      end
      tick();
      bus.tail = '0;
      for (int g = 0; g < 6; g++) begin
        e = -1;
        for (int k = 0; k < CH; k++) begin
          c = (m_rr + k) % CH;
          if (e < 0 && (m_burst[c] || m_tail[c]) && !m_empty[c]) e = c;
        end
        if (e < 0) begin
          seen = 1'b0;
          repeat (8) begin
            if (bus.burst_req || bus.tail_req) seen = 1'b1;
            tick();
          end
          total++; if (seen !== 1'b0) begin bad++; $display("FAIL rnd_spurious s=%0d got=%b want=0", s, seen); end
          break;
        end
        wait_req(12, ok);
        total++; if (!ok) begin bad++; $display("FAIL rnd_timeout s=%0d got=none want=ch%0d", s, e); break; end
        exp_tail = !m_burst[e];
        exp_len = m_burst[e] ? THR : m_cnt[e];
        total++; if (bus.req_ch !== 2'(e)) begin bad++; $display("FAIL rnd_ch s=%0d got=%0d want=%0d", s, bus.req_ch, e); end
        total++; if ({bus.burst_req, bus.tail_req} !== {!exp_tail, exp_tail}) begin bad++; $display("FAIL rnd_kind s=%0d got=%b want=%b", s, {bus.burst_req, bus.tail_req}, {!exp_tail, exp_tail}); end
        total++; if (bus.req_len !== 9'(exp_len)) begin bad++; $display("FAIL rnd_len s=%0d got=%0d want=%0d", s, bus.req_len, exp_len); end
        repeat ($urandom_range(0, 3)) tick();
        total++; if ((bus.burst_req | bus.tail_req) !== 1'b1) begin bad++; $display("FAIL rnd_hold s=%0d got=0 want=1", s); end
        bus.resp = 1'b1;
        tick();
        bus.resp = 1'b0;
        total++; if ({bus.burst_req, bus.tail_req} !== 2'b00) begin bad++; $display("FAIL rnd_drop s=%0d got=%b want=00", s, {bus.burst_req, bus.tail_req}); end
        repeat ($urandom_range(0, 3)) tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        if (exp_tail) m_tail[e] = 1'b0;
        m_rr = (e + 1) % CH;
      end
      quiet();
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    test_reset();
    test_burst();
    test_round_robin();
    test_tail();
    test_burst_then_tail();
    test_resp_done_same();
    test_async_reset();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
